// File: rtl/uart_bytes_rx.sv
// uart_bytes_rx: 16x-oversampled UART byte receiver (8N1 by default).
// Each bit is sampled at oversample points 7, 8 and 9 and decided by a 2-of-3
// majority vote. A good frame updates data and emits a one-cycle rx_done. A
// bad stop bit emits a one-cycle frame_err and leaves data unchanged.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits. PARITY_ODD selects the parity sense (0 = even, 1 = odd).
// The receiver returns to IDLE at the stop-bit decision point, so it can catch
// a start edge that immediately follows the stop bit.
module uart_bytes_rx #(
    parameter int CLK_FREQ = 50_000_000
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       uart_state,
    output logic       frame_err
);

    // The slowest rate (9600) needs the largest divider, so it sets the width.
    localparam int DIV_MAX = CLK_FREQ / (9600 * 16) - 1;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ / (9600 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ / (19200 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ / (38400 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ / (57600 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ / (115200 * 16) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    logic [2:0]       baud_reg;
    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] tick_cnt_reg;
    logic [3:0]       sample_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic             vote7_reg;
    logic             vote8_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             rx_done_reg;
    logic             frame_err_reg;

    logic             start_det;
    logic             tick;
    logic             at_sample9;
    logic             bit_wrap;
    logic             voted;
    logic             parity_ok;
    logic             accept;
    logic             reject;

    // Synchronizer and edge-detect flops; they idle high like the line.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign start_det  = (state_reg == ST_IDLE) && rx_prev_reg && !rx_sync_reg;
    assign tick       = (state_reg != ST_IDLE) && (tick_cnt_reg == div_sel);
    assign at_sample9 = tick && (sample_cnt_reg == 4'd9);
    assign bit_wrap   = tick && (sample_cnt_reg == 4'd15);
    // Samples 7 and 8 are stored; sample 9 is the live synchronized line.
    assign voted      = (vote7_reg & vote8_reg) | (vote7_reg & rx_sync_reg) |
                        (vote8_reg & rx_sync_reg);

`ifdef UART_RX_PARITY_EN
    logic parity_bit_reg;

    // Parity bit capture, sampled and voted like any data bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            parity_bit_reg <= 1'b0;
        end else if ((state_reg == ST_PARITY) && at_sample9) begin
            parity_bit_reg <= voted;
        end
    end

    assign parity_ok = (((^shift_reg) ^ parity_bit_reg) == PARITY_ODD);
`else
    assign parity_ok = 1'b1;
`endif

    // Divider reload value for the baud rate latched at start detect.
    always_comb begin
        div_sel = DIV_115200;
        case (baud_reg)
            3'd0:    div_sel = DIV_9600;
            3'd1:    div_sel = DIV_19200;
            3'd2:    div_sel = DIV_38400;
            3'd3:    div_sel = DIV_57600;
            default: div_sel = DIV_115200;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the accept/reject decision at the stop bit.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_det) state_next = ST_START;
            end
            ST_START: begin
                if (at_sample9 && voted) begin
                    state_next = ST_IDLE;
                end else if (bit_wrap) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_wrap && (bit_cnt_reg == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_wrap) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (at_sample9) begin
                    accept     = voted && parity_ok;
                    reject     = !(voted && parity_ok);
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Oversampling counters; they rest at zero in IDLE, so tick phase is
    // referenced to the start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_reg   <= '0;
            sample_cnt_reg <= 4'd0;
            bit_cnt_reg    <= 3'd0;
        end else if (state_reg == ST_IDLE) begin
            tick_cnt_reg   <= '0;
            sample_cnt_reg <= 4'd0;
            bit_cnt_reg    <= 3'd0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + DIV_W'(1);
            if (tick) sample_cnt_reg <= sample_cnt_reg + 4'd1;
            if ((state_reg == ST_DATA) && bit_wrap) bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    // Baud latch, vote samples and LSB-first shift register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_reg  <= 3'd0;
            vote7_reg <= 1'b1;
            vote8_reg <= 1'b1;
            shift_reg <= 8'h00;
        end else begin
            if (start_det) baud_reg <= baud_set;
            if (tick && (sample_cnt_reg == 4'd7)) vote7_reg <= rx_sync_reg;
            if (tick && (sample_cnt_reg == 4'd8)) vote8_reg <= rx_sync_reg;
            if ((state_reg == ST_DATA) && at_sample9) shift_reg <= {voted, shift_reg[7:1]};
        end
    end

    // Output register: data and the two mutually exclusive one-cycle strobes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_reg      <= 8'h00;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_done_reg   <= accept;
            frame_err_reg <= reject;
            if (accept) data_reg <= shift_reg;
        end
    end

    assign data       = data_reg;
    assign rx_done    = rx_done_reg;
    assign frame_err  = frame_err_reg;
    assign uart_state = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_bytes_rx.sv
// Testbench for uart_bytes_rx: serial frames are driven at the rate implied by
// the divider formula, the expected outcome of every frame is queued when the
// frame is issued, and a separate monitor pops and checks on each strobe.
`timescale 1ns/1ps
module tb_uart_bytes_rx;

    // Clock chosen so that every supported rate divides exactly and the run stays short.
    localparam int  CLK_FREQ = 7_372_800;
    localparam bit  PAR_ODD  = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] baud_set;
    logic       uart_rx;
    logic [7:0] data;
    logic       rx_done;
    logic       uart_state;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_bytes_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .baud_set  (baud_set),
        .uart_rx   (uart_rx),
        .data      (data),
        .rx_done   (rx_done),
        .uart_state(uart_state),
        .frame_err (frame_err)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    longint     last_done_cyc = 0;
    logic [7:0] model_data = 8'h00;
    bit         prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: nominal baud rate and the resulting clocks per bit.
    function automatic int baud_of(input logic [2:0] s);
        case (s)
            3'd0:    return 9600;
            3'd1:    return 19200;
            3'd2:    return 38400;
            3'd3:    return 57600;
            default: return 115200;
        endcase
    endfunction

    function automatic int bit_clks(input logic [2:0] s);
        return 16 * (CLK_FREQ / (baud_of(s) * 16));
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks that data holds otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (rx_done || frame_err) begin
                exp_t e;
                check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rx_done, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        model_data = e.d;
                        last_done_cyc = cyc;
                    end
                    check("data_value", data, model_data);
                    $display("frame %s data=%02h expected=%02h", rx_done ? "done" : "err ", data, model_data);
                end
            end else begin
                check("data_hold", data, model_data);
            end
            prev_pulse = rx_done || frame_err;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        uart_rx = v;
        wait_clks(n);
    endtask

    // Drive one frame and queue its expected outcome; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int bc);
        exp_t e;
        logic pbit;
        pbit     = (^b) ^ PAR_ODD ^ !par_ok;
        e.d      = b;
`ifdef UART_RX_PARITY_EN
        e.is_err = !stop_ok || !par_ok;
`else
        e.is_err = !stop_ok;
`endif
        exp_q.push_back(e);
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) drive(b[i], bc);
`ifdef UART_RX_PARITY_EN
        drive(pbit, bc);
`endif
        drive(stop_ok, bc);
    endtask

    initial begin
        longint t0;
        int     bc;
        uart_rx  = 1'b1;
        baud_set = 3'd4;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        wait_clks(4);
        check("reset_data", data, 8'h00);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_state", {31'd0, uart_state}, 32'd0);
        rst_n = 1'b1;

        // Idle line for 10 us: nothing happens.
        for (int i = 0; i < 10; i++) begin
            wait_clks(100);
            check("idle_state", {31'd0, uart_state}, 32'd0);
        end

        // Single byte at 115200 with latency and uart_state checks.
        bc = bit_clks(3'd4);
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b1, bc);
            begin
                wait_clks(5 * bc);
                check("state_mid_frame", {31'd0, uart_state}, 32'd1);
            end
        join
        drive(1'b1, bc);
        check("done_latency_window",
              {31'd0, (last_done_cyc - t0 >= 154 * bc / 16) && (last_done_cyc - t0 <= 154 * bc / 16 + 8)},
              32'd1);
        check("state_after_frame", {31'd0, uart_state}, 32'd0);

        // Back-to-back frames at 9600, no idle gap.
        baud_set = 3'd0;
        bc = bit_clks(3'd0);
        send_frame(8'h00, 1'b1, 1'b1, bc);
        send_frame(8'hFF, 1'b1, 1'b1, bc);
        send_frame(8'h3C, 1'b1, 1'b1, bc);
        drive(1'b1, bc);

        // 100-clock glitch on the idle line is rejected at the start check.
        drive(1'b0, 100);
        check("glitch_state_high", {31'd0, uart_state}, 32'd1);
        drive(1'b1, 600);
        check("glitch_state_low", {31'd0, uart_state}, 32'd0);
        drive(1'b1, bc);

        // Framing error: stop bit forced low, data keeps the previous byte.
        baud_set = 3'd4;
        bc = bit_clks(3'd4);
        send_frame(8'h55, 1'b0, 1'b1, bc);
        drive(1'b1, bc);

        // Break: one frame error, then silence while the line stays low.
        send_frame(8'h00, 1'b0, 1'b1, bc);
        drive(1'b0, 20 * bc);
        check("break_state", {31'd0, uart_state}, 32'd0);
        drive(1'b1, 2 * bc);

        // Good byte so that data is non-zero before the mid-frame reset.
        send_frame(8'h96, 1'b1, 1'b1, bc);
        drive(1'b1, bc);

        // Reset during data bit 4: asynchronous clear, then a clean byte.
        drive(1'b0, bc);
        for (int i = 0; i < 4; i++) drive(i[0], bc);
        drive(1'b1, bc / 2);
        rst_n = 1'b0;
        #1;
        check("async_reset_data", data, 8'h00);
        check("async_reset_state", {31'd0, uart_state}, 32'd0);
        check("async_reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("async_reset_frame_err", {31'd0, frame_err}, 32'd0);
        wait_clks(5);
        uart_rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        drive(1'b1, 2 * bc);
        send_frame(8'h81, 1'b1, 1'b1, bc);
        drive(1'b1, bc);

        // baud_set change mid-frame is ignored until the next start edge.
        fork
            send_frame(8'hC3, 1'b1, 1'b1, bc);
            begin
                wait_clks(2 * bc);
                baud_set = 3'd0;
            end
        join
        drive(1'b1, bc);
        baud_set = 3'd4;
        drive(1'b1, bc);

`ifdef UART_RX_PARITY_EN
        // Parity: good even parity accepted, bad parity flagged.
        send_frame(8'h07, 1'b1, 1'b1, bc);
        drive(1'b1, bc);
        send_frame(8'h07, 1'b1, 1'b0, bc);
        drive(1'b1, bc);
`endif

        // Randomized frames at the faster rates.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            bit         s_ok;
            bit         p_ok;
            int         gap;
            baud_set = 3'($urandom_range(1, 7));
            bc   = bit_clks(baud_set);
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = ($urandom_range(0, 4) != 0);
            send_frame(b, s_ok, p_ok, bc);
            gap  = s_ok ? int'($urandom_range(0, bc)) : bc;
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, 2 * bc);

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) wait_clks(1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
